// File: rtl/led_pkg.sv
// Shared types and defaults for the LED burst-blink sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pkg;

  // Sequencer state encoding, fixed so status decoding stays stable.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Default prescaler ratio: clk cycles per phase tick.
  localparam int DEF_DIV = 50000;

endpackage

// File: rtl/led_tick_gen.sv
// Tick prescaler: one-cycle tick every DIV clocks while running.
// Latency: first tick DIV cycles after i_RUN rises with the counter cleared.
// Backpressure: none; i_CLR or a dropped i_RUN resets the count to zero.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int DIV   = DEF_DIV,
  parameter int DIV_W = 16
) (
  input  logic i_CLK,
  input  logic i_RST_N,
  input  logic i_CLR,
  input  logic i_RUN,
  output logic o_TICK
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt;

  // Free-running 0..DIV-1 counter, held at zero while idle or cleared.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      cnt <= '0;
    end else if (i_CLR || !i_RUN) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign o_TICK = i_RUN & ~i_CLR & (cnt == LAST);

endmodule

// File: rtl/led_blink_ctrl.sv
// Burst-blink sequencer: drives the LED through COUNT ON/OFF phase pairs per request.
// Latency: LED rises the cycle after accept; burst = COUNT*(on+off)*DIV cycles + 1 DONE cycle.
// Backpressure: o_REQ_READY high only in IDLE; requests presented while busy are ignored.
module led_blink_ctrl
  import led_pkg::*;
#(
  parameter int DIV    = DEF_DIV,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 4,
  parameter int TICK_W = 8
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  input  logic              i_REQ_VALID,
  output logic              o_REQ_READY,
  input  logic [CNT_W-1:0]  i_REQ_COUNT,
  input  logic [TICK_W-1:0] i_REQ_ON,
  input  logic [TICK_W-1:0] i_REQ_OFF,
  input  logic              i_ABORT,
  output logic              o_LED,
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic [CNT_W-1:0]  o_BLINKS_LEFT
);

  state_t             state, nxt_state;
  logic [TICK_W-1:0]  on_last, off_last;
  logic [TICK_W-1:0]  phase_cnt, nxt_phase;
  logic [CNT_W-1:0]   blinks_left, nxt_blinks;
  logic               led, busy, done, ready;
  logic               accept, tick, run, clr;

  assign accept = i_REQ_VALID & (state == S_IDLE);
  assign run    = (state == S_ON) | (state == S_OFF);
  assign clr    = accept | (state == S_IDLE) | (state == S_DONE);

  led_tick_gen #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_tick (
    .i_CLK   (i_CLK),
    .i_RST_N (i_RST_N),
    .i_CLR   (clr),
    .i_RUN   (run),
    .o_TICK  (tick)
  );

  // Next-state, phase counter and blink counter decisions.
  always_comb begin
    nxt_state  = state;
    nxt_phase  = phase_cnt;
    nxt_blinks = blinks_left;
    case (state)
      S_IDLE: begin
        nxt_phase = '0;
        if (accept) begin
          if (i_REQ_COUNT != '0) begin
            nxt_state  = S_ON;
            nxt_blinks = i_REQ_COUNT;
          end else begin
            nxt_state = S_DONE;
          end
        end
      end
      S_ON: begin
        if (i_ABORT) begin
          nxt_state  = S_DONE;
          nxt_phase  = '0;
          nxt_blinks = '0;
        end else if (tick) begin
          if (phase_cnt == on_last) begin
            nxt_state = S_OFF;
            nxt_phase = '0;
          end else begin
            nxt_phase = phase_cnt + TICK_W'(1);
          end
        end
      end
      S_OFF: begin
        if (i_ABORT) begin
          nxt_state  = S_DONE;
          nxt_phase  = '0;
          nxt_blinks = '0;
        end else if (tick) begin
          if (phase_cnt == off_last) begin
            nxt_phase  = '0;
            nxt_blinks = blinks_left - CNT_W'(1);
            nxt_state  = (blinks_left == CNT_W'(1)) ? S_DONE : S_ON;
          end else begin
            nxt_phase = phase_cnt + TICK_W'(1);
          end
        end
      end
      S_DONE: begin
        nxt_state = S_IDLE;
        nxt_phase = '0;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state       <= S_IDLE;
      phase_cnt   <= '0;
      blinks_left <= '0;
      led         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ready       <= 1'b1;
    end else begin
      state       <= nxt_state;
      phase_cnt   <= nxt_phase;
      blinks_left <= nxt_blinks;
      led         <= (nxt_state == S_ON);
      busy        <= (nxt_state == S_ON) | (nxt_state == S_OFF);
      done        <= (nxt_state == S_DONE);
      ready       <= (nxt_state == S_IDLE);
    end
  end

  // Latch phase lengths at accept as last-tick indices; zero length acts as one tick.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      on_last  <= '0;
      off_last <= '0;
    end else if (accept) begin
      on_last  <= (i_REQ_ON  == '0) ? '0 : i_REQ_ON  - TICK_W'(1);
      off_last <= (i_REQ_OFF == '0) ? '0 : i_REQ_OFF - TICK_W'(1);
    end
  end

  assign o_LED         = led;
  assign o_BUSY        = busy;
  assign o_DONE        = done;
  assign o_REQ_READY   = ready;
  assign o_BLINKS_LEFT = blinks_left;

endmodule
